// File: rtl/add_result_unpacker_128.sv
// add_result_unpacker_128
// Captures the full-width carry-select adder sum into a shadow register on the
// adder's one-cycle strobe. It then drains the sum LSW-first as BLOCK-bit words
// over valid/ready, so the adder can start its next operation meanwhile.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   c_in          adder sum, word k = c_in[BLOCK*k +: BLOCK]
//   en_in         one-cycle capture strobe
//   out_ready     sink accepts the current word
//   out_valid     out_data/out_addr hold a valid word
//   out_data      current word
//   out_addr      index of current word
//   out_last      current word is the final one
//   busy          result held and not yet fully transferred
//   done          one-cycle pulse after the final word transferred
//   overrun       sticky: strobe arrived while busy and was dropped
//   clr_overrun   synchronous clear of overrun (a new overrun wins)
module add_result_unpacker_128 #(
  parameter int unsigned BLOCK  = 128,
  parameter int unsigned WORDS  = 25,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BLOCK*WORDS-1:0]   c_in,
  input  logic                     en_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [BLOCK-1:0]         out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

  logic [0:0]        state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic [BLOCK-1:0]  shadow [WORDS];
  logic [BLOCK-1:0]  data_nx;
  logic              load, done_nx, ovr_set, overrun_nx, last_nx;
  logic              hs, at_last;

  // out_valid is exactly "in SEND", so the handshake needs no output feedback
  assign hs      = (state == SEND) && out_ready;
  assign at_last = (idx == LAST_IDX);

  // Next-state, index, and next registered output values
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    load     = 1'b0;
    done_nx  = 1'b0;
    ovr_set  = 1'b0;
    data_nx  = out_data;
    case (state)
      IDLE: begin
        if (en_in) begin
          load     = 1'b1;
          idx_nx   = '0;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (hs && at_last) begin
          // A strobe on the final handshake starts the next result seamlessly
          done_nx = 1'b1;
          if (en_in) begin
            load   = 1'b1;
            idx_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          if (hs) idx_nx = ADDR_W'(idx + ADDR_W'(1));
          if (en_in) ovr_set = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Word 0 comes straight from c_in on capture, later words from the shadow
    if (load) begin
      data_nx = c_in[BLOCK-1:0];
    end else if (hs && !at_last) begin
      data_nx = shadow[idx_nx];
    end

    overrun_nx = ovr_set | (overrun & ~clr_overrun);
    last_nx    = (state_nx == SEND) && (idx_nx == LAST_IDX);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      out_data <= data_nx;
      out_last <= last_nx;
      done     <= done_nx;
      overrun  <= overrun_nx;
    end
  end

  // Shadow copy of the sum, written only on an accepted strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < WORDS; k++) shadow[k] <= '0;
    end else if (load) begin
      for (int unsigned k = 0; k < WORDS; k++) shadow[k] <= c_in[BLOCK*k +: BLOCK];
    end
  end

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_addr  = idx;

endmodule

// File: doc/add_result_unpacker_128.md
# add_result_unpacker_128

Downstream stage of the 3200-bit (25 × 128-bit) carry-select adder. On the adder's one-cycle `en_out` strobe it captures the full-width sum into a shadow register. It then streams the sum least-significant word first as 25 × 128-bit words over a valid/ready interface to the URAM write port. This frees the adder to start the next operation while the previous result is drained.

## Interface
- `Block`, 128, word width in bits
- `Words`, 25, number of words per result
- `Addr_w`, 5, width of word index, must satisfy 2^Addr_w ≥ Words

- `clk`  in  1  clock; reset `rst_n`, asynchronous, active-low
- `rst_n`  in  1  asynchronous active-low reset
- `c_in`  in  Block*Words  adder sum; word k is `c_in[Block*k +: Block]`
- `en_in`  in  1  one-cycle capture strobe (driven by adder `en_out`)
- `out_ready`  in  1  sink can accept a word this cycle
- `out_valid`  out  1  `out_data`/`out_addr` hold a valid word
- `out_data`  out  Block  current word
- `out_addr`  out  Addr_w  index of current word, 0..Words-1
- `out_last`  out  1  high with `out_valid` when `out_addr == Words-1`
- `busy`  out  1  result held and not yet fully transferred
- `done`  out  1  one-cycle pulse after final word transferred
- `overrun`  out  1  sticky: capture strobe arrived while busy and was dropped
- `clr_overrun`  in  1  synchronous clear of `overrun`

## Operation
- States: IDLE, SEND.
- IDLE + `en_in`: latch `c_in` into shadow; idx←0; go to SEND.
- SEND: `out_valid`=1, `out_data`=shadow word idx, `out_addr`=idx.
  - Handshake is `out_valid && out_ready`.
  - On handshake with idx<Words-1: idx←idx+1.
  - On handshake with idx==Words-1: `done` pulses next cycle, go to IDLE.
- Without a handshake, `out_data`/`out_addr`/`out_valid` hold stable; valid never drops until the transfer completes.
- `en_in` on the final-handshake cycle: accepted. Re-latch shadow, idx←0, stay in SEND. `done` still pulses; no overrun.
- `en_in` in any other SEND cycle: ignored, shadow untouched, `overrun`←1.
- `clr_overrun` and a new overrun in the same cycle: `overrun` stays 1 (set wins).
- `busy` = (state == SEND).
- No arithmetic on data; words pass bit-exact. Shadow is Block*Words bits; `out_data` is a registered or mux-from-shadow word selected by idx.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `busy`=0, `done`=0, `overrun`=0; shadow cleared; state IDLE.
- Reset asserted mid-transfer: immediate abort; no `done` pulse; stream resumes only after a new `en_in`.
- `en_in` sampled at edge N → `out_valid`=1 and word 0 visible after edge N (cycle N+1).
- With `out_ready` held high: one word per cycle. Words 0..24 appear in cycles N+1..N+25. `done`=1 in cycle N+26, `busy`=0 in cycle N+26.
- `c_in` is only sampled at the `en_in` edge; it may change freely afterwards.
- `out_ready` may toggle arbitrarily; no combinational path from `out_ready` to `out_valid`.

## Test plan
- Basic stream: `c_in` word k = {k, 120'h0} (word k's top byte = k); `en_in` pulse, `out_ready`=1.
  - Words k=0..24 appear on consecutive cycles with `out_addr`=k.
  - `out_last` high only at k=24; `done` one cycle later; `busy` falls with `done`.
- Backpressure: same data, `out_ready` pattern 1,0,0,1 repeating.
  - Each word is held stable while ready=0.
  - Exactly 25 handshakes; no duplicate or skipped addr.
- Input isolation: change `c_in` to all-ones one cycle after `en_in`.
  - The streamed words still match the captured pattern.
- Overrun: second `en_in` at addr 10.
  - Stream of first result completes unchanged; `overrun`=1 and sticky.
  - `clr_overrun` pulse → `overrun`=0 next cycle.
- Back-to-back: second `en_in` (all words 128'hA5…A5) on the addr-24 handshake cycle.
  - `done` pulses; `out_valid` stays 1; addr restarts at 0 with A5 data; `overrun`=0.
- Reset mid-op: drop `rst_n` at addr 7.
  - All outputs go to 0 asynchronously, no `done`.
  - After release, a fresh `en_in` streams from addr 0.
